fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of decode.
- Owns the PC, issues requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register that decode reads.
- Obeys the hazard unit's PC/IF-ID write enables and redirects on a taken branch resolved in decode, flushing the wrong-path instruction.
- Holds a one-entry skid buffer so a response that arrives during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on bubble or flush.

Ports:
- clk  input  1  single clock for the whole stage.
- reset  input  1  asynchronous, active-high reset.
- write_pc  input  1  hazard unit; 0 = hold the PC.
- write_ifid  input  1  hazard unit; 0 = hold IF/ID.
- branch_taken  input  1  decode; taken-branch redirect, one-cycle pulse.
- branch_target  input  32  decode; redirect address, valid with branch_taken.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals the PC.
- imem_ready  input  1  memory response valid this cycle; may be high in the same cycle as imem_req.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- instruction  output  32  IF/ID instruction, read by decode.
- pc_plus4  output  32  IF/ID: fetched PC + 4.
- ifid_valid  output  1  IF/ID contents are a real instruction.

Behaviour:
- Stall term: stall = !write_pc | !write_ifid. The two enables are treated as one stall.
- Reset (asynchronous, active-high):
  - pc = RESET_PC, state = FETCH.
  - instruction = NOP_INSTR, pc_plus4 = 0, ifid_valid = 0.
  - skid = 0, redirect_pc = 0.
  - imem_req = 0 while reset is high; it rises in the first cycle after release.
- Handshake:
  - A request is accepted when imem_req & imem_ready.
  - Once raised, imem_req stays high and imem_addr stays stable until accepted. A request is never withdrawn.
- imem_req is 1 in FETCH and KILL, 0 in HOLD.
- State FETCH:
  - branch_taken & imem_ready: pc <= branch_target; IF/ID flushed (NOP_INSTR, valid=0); response discarded; stay FETCH.
  - branch_taken & !imem_ready: redirect_pc <= branch_target; IF/ID flushed; pc unchanged; go KILL.
  - imem_ready & !stall: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
  - imem_ready & stall: skid <= imem_rdata; IF/ID and pc unchanged; go HOLD.
  - !imem_ready & !stall: IF/ID loads a bubble (NOP_INSTR, valid=0; pc_plus4 don't-care, drive pc+4).
  - !imem_ready & stall: IF/ID unchanged.
- State HOLD (skid full, no request outstanding):
  - branch_taken: pc <= branch_target; IF/ID flushed; skid discarded; go FETCH.
  - !stall: IF/ID <= {skid, pc+4, valid=1}; pc <= pc+4; go FETCH.
  - stall: hold everything.
- State KILL (draining a wrong-path request):
  - While waiting: IF/ID holds the flush value.
  - Another branch_taken overwrites redirect_pc.
  - imem_ready: response discarded; pc <= redirect_pc, or branch_target if branch_taken in the same cycle; go FETCH.
- Priority: reset > branch_taken > stall > normal advance.
- Latency: the instruction at PC appears on IF/ID in the cycle after acceptance. Zero-wait memory gives one instruction per cycle.
- Arithmetic: pc+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC advances to 0 with no flag. The low 2 PC bits are not checked.
- Reset mid-operation: all state is lost immediately; any outstanding memory response after reset is ignored because no request is considered outstanding.
- Encoding: FSM is 2-bit; the unused encoding returns to FETCH.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum (FETCH, HOLD, KILL);
  - NOP_INSTR constant;
  - default RESET_PC;
  - instruction/address width constant (32).
- One natural sub-module: if_id_reg, the IF/ID pipeline register.
  - Inputs: write enable, flush, bubble, {instruction, pc_plus4, valid}.
  - Flush and bubble both load NOP_INSTR with valid=0.

Test Plan:
- Reset then zero-wait memory (ready tied 1, rdata=addr^32'hA5A5_0000) -> imem_addr 0,4,8,… on consecutive cycles; IF/ID valid from cycle 2; pc_plus4 = addr+4.
- Memory ready 3 cycles after req at pc=0x10 -> imem_addr held 0x10 for all 3 cycles; IF/ID shows 2 bubbles (valid=0), then instruction with pc_plus4=0x14.
- Response accepted while write_pc=write_ifid=0 for 2 cycles -> HOLD with imem_req=0; when enables rise, IF/ID gets the skid word and the next request goes to pc+4, with no word lost or duplicated.
- branch_taken with target 0x100 while the request at 0x20 is still pending -> KILL; 0x20 data discarded; next request at 0x100; IF/ID valid=0 until 0x100 returns.
- branch_taken and stall in the same cycle in HOLD -> pc=0x100, skid discarded, IF/ID flushed; branch wins.
- PC at 0xFFFF_FFFC, accepted fetch -> pc wraps to 0, pc_plus4=0. Reset asserted mid-wait -> outputs return to reset values asynchronously and imem_req drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-stage types, widths and default encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned c_xlen = 32;

  localparam logic [c_xlen-1:0] c_nopInstr = 32'h0000_0000;
  localparam logic [c_xlen-1:0] c_resetPc  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    KILL  = 2'b10
  } fetchState_t;

  // Sequential PC advance; wraps modulo 2^32 with no overflow indication.
  function automatic logic [c_xlen-1:0] pcIncr(input logic [c_xlen-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register; flush and bubble both insert a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [c_xlen-1:0] NOP_INSTR = c_nopInstr
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_writeEn,
  input  logic              i_flush,
  input  logic              i_bubble,
  input  logic [c_xlen-1:0] i_instr,
  input  logic [c_xlen-1:0] i_pcPlus4,
  input  logic              i_valid,
  output logic [c_xlen-1:0] o_instr,
  output logic [c_xlen-1:0] o_pcPlus4,
  output logic              o_valid
);

  logic [c_xlen-1:0] r_instr;
  logic [c_xlen-1:0] r_pcPlus4;
  logic              r_valid;

  // Flush ignores the write enable: a redirect must beat a hazard stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= i_pcPlus4;
      r_valid   <= 1'b0;
    end else if (i_writeEn) begin
      r_pcPlus4 <= i_pcPlus4;
      if (i_bubble) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_instr <= i_instr;
        r_valid <= i_valid;
      end
    end
  end

  assign o_instr   = r_instr;
  assign o_pcPlus4 = r_pcPlus4;
  assign o_valid   = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with req/ready memory handshake, one-entry
//               skid buffer, hazard stalls and decode-resolved branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [c_xlen-1:0] RESET_PC  = c_resetPc,
  parameter logic [c_xlen-1:0] NOP_INSTR = c_nopInstr
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_pc,
  input  logic              write_ifid,
  input  logic              branch_taken,
  input  logic [c_xlen-1:0] branch_target,
  output logic              imem_req,
  output logic [c_xlen-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [c_xlen-1:0] imem_rdata,
  output logic [c_xlen-1:0] instruction,
  output logic [c_xlen-1:0] pc_plus4,
  output logic              ifid_valid
);

  fetchState_t       r_state;
  fetchState_t       w_nextState;
  logic [c_xlen-1:0] r_pc;
  logic [c_xlen-1:0] w_nextPc;
  logic [c_xlen-1:0] r_skid;
  logic [c_xlen-1:0] w_nextSkid;
  logic [c_xlen-1:0] r_redirectPc;
  logic [c_xlen-1:0] w_nextRedirect;
  logic              r_active;

  logic              w_stall;
  logic              w_accept;
  logic              w_ifidWe;
  logic              w_ifidFlush;
  logic              w_ifidBubble;
  logic [c_xlen-1:0] w_ifidInstr;

  assign w_stall  = !write_pc | !write_ifid;
  // r_active keeps the request low through reset and the first edge after it,
  // so a stray ready in that window never counts as an acceptance.
  assign imem_req  = r_active & ((r_state == FETCH) | (r_state == KILL));
  assign imem_addr = r_pc;
  assign w_accept  = imem_req & imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_skid       <= '0;
      r_redirectPc <= '0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_skid       <= w_nextSkid;
      r_redirectPc <= w_nextRedirect;
      r_active     <= 1'b1;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextSkid     = r_skid;
    w_nextRedirect = r_redirectPc;
    w_ifidWe       = 1'b0;
    w_ifidFlush    = 1'b0;
    w_ifidBubble   = 1'b0;
    w_ifidInstr    = imem_rdata;
    case (r_state)
      FETCH: begin
        if (branch_taken) begin
          w_ifidFlush = 1'b1;
          if (w_accept) begin
            w_nextPc = branch_target;
          end else begin
            w_nextRedirect = branch_target;
            w_nextState    = KILL;
          end
        end else if (w_accept) begin
          if (!w_stall) begin
            w_ifidWe = 1'b1;
            w_nextPc = pcIncr(r_pc);
          end else begin
            w_nextSkid  = imem_rdata;
            w_nextState = HOLD;
          end
        end else if (!w_stall) begin
          w_ifidWe     = 1'b1;
          w_ifidBubble = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          w_nextPc    = branch_target;
          w_ifidFlush = 1'b1;
          w_nextState = FETCH;
        end else if (!w_stall) begin
          w_ifidWe    = 1'b1;
          w_ifidInstr = r_skid;
          w_nextPc    = pcIncr(r_pc);
          w_nextState = FETCH;
        end
      end
      KILL: begin
        // The wrong-path response is still owed; drain it, then redirect.
        w_ifidFlush = 1'b1;
        if (branch_taken) begin
          w_nextRedirect = branch_target;
        end
        if (w_accept) begin
          w_nextPc    = branch_taken ? branch_target : r_redirectPc;
          w_nextState = FETCH;
        end
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifId (
    .clk       (clk),
    .rst       (reset),
    .i_writeEn (w_ifidWe),
    .i_flush   (w_ifidFlush),
    .i_bubble  (w_ifidBubble),
    .i_instr   (w_ifidInstr),
    .i_pcPlus4 (pcIncr(r_pc)),
    .i_valid   (1'b1),
    .o_instr   (instruction),
    .o_pcPlus4 (pc_plus4),
    .o_valid   (ifid_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        write_pc;
  logic        write_ifid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        ifid_valid;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] c_pat = 32'hA5A5_0000;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_pc      (write_pc),
    .write_ifid    (write_ifid),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_plus4      (pc_plus4),
    .ifid_valid    (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr ^ pattern so every word identifies its own address.
  assign imem_rdata = imem_ready ? (imem_addr ^ c_pat) : 32'hDEAD_BEEF;

  task automatic test_reset();
    reset = 1'b1; write_pc = 1'b1; write_ifid = 1'b1;
    branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instruction); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got=%h exp=0", pc_plus4); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ifid_valid); end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_first_req got=%0b exp=1", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL zw_first_valid got=%0b exp=0", ifid_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (imem_addr !== 32'(4 * (k + 1))) begin errors++; $display("FAIL zw_addr[%0d] got=%h exp=%h", k, imem_addr, 32'(4 * (k + 1))); end
      checks++; if (instruction !== (32'(4 * k) ^ c_pat)) begin errors++; $display("FAIL zw_instr[%0d] got=%h exp=%h", k, instruction, 32'(4 * k) ^ c_pat); end
      checks++; if (pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL zw_pcp4[%0d] got=%h exp=%h", k, pc_plus4, 32'(4 * k + 4)); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got=%0b exp=1", k, ifid_valid); end
    end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL ws_hold[%0d] req=%0b addr=%h exp req=1 addr=10", k, imem_req, imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL ws_bubble[%0d] got=%0b exp=0", k, ifid_valid); end
    end
    imem_ready = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0010) begin errors++; $display("FAIL ws_instr got=%h exp=a5a50010", instruction); end
    checks++; if (pc_plus4 !== 32'h14 || ifid_valid !== 1'b1) begin errors++; $display("FAIL ws_pcp4 got=%h/%0b exp=14/1", pc_plus4, ifid_valid); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL ws_next_addr got=%h exp=14", imem_addr); end
  endtask

  task automatic test_stall_skid();
    write_pc = 1'b0; write_ifid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_req[%0d] got=%0b exp=0", k, imem_req); end
      checks++; if (instruction !== 32'hA5A5_0010 || ifid_valid !== 1'b1) begin errors++; $display("FAIL sk_ifid_hold[%0d] got=%h/%0b exp=a5a50010/1", k, instruction, ifid_valid); end
    end
    write_pc = 1'b1; write_ifid = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0014 || pc_plus4 !== 32'h18) begin errors++; $display("FAIL sk_release got=%h/%h exp=a5a50014/18", instruction, pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin errors++; $display("FAIL sk_next_req req=%0b addr=%h exp 1/18", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0018 || pc_plus4 !== 32'h1C) begin errors++; $display("FAIL sk_following got=%h/%h exp=a5a50018/1c", instruction, pc_plus4); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL sk_addr20 got=%h exp=20", imem_addr); end
  endtask

  task automatic test_branch_kill();
    imem_ready = 1'b0;
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL bk_pending req=%0b addr=%h exp 1/20", imem_req, imem_addr); end
    checks++; if (ifid_valid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL bk_flush got=%h/%0b exp=0/0", instruction, ifid_valid); end
    branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bk_redirect got=%h exp=100", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL bk_discard got=%0b exp=0 instr=%h", ifid_valid, instruction); end
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0100 || pc_plus4 !== 32'h104 || ifid_valid !== 1'b1) begin errors++; $display("FAIL bk_target_word got=%h/%h/%0b exp=a5a50100/104/1", instruction, pc_plus4, ifid_valid); end
  endtask

  task automatic test_branch_in_hold();
    write_pc = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bh_hold_req got=%0b exp=0", imem_req); end
    branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL bh_pc req=%0b addr=%h exp 1/100", imem_req, imem_addr); end
    checks++; if (ifid_valid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL bh_flush got=%h/%0b exp=0/0", instruction, ifid_valid); end
    branch_taken = 1'b0; branch_target = '0; write_pc = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0100 || pc_plus4 !== 32'h104) begin errors++; $display("FAIL bh_skid_dropped got=%h/%h exp=a5a50100/104", instruction, pc_plus4); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0; branch_target = '0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || ifid_valid !== 1'b0) begin errors++; $display("FAIL wr_redirect addr=%h valid=%0b exp fffffffc/0", imem_addr, ifid_valid); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wr_pc got=%h exp=0", imem_addr); end
    checks++; if (pc_plus4 !== 32'h0 || instruction !== 32'h5A5A_FFFC || ifid_valid !== 1'b1) begin errors++; $display("FAIL wr_ifid got=%h/%h/%0b exp=5a5afffc/0/1", instruction, pc_plus4, ifid_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rm_waiting req=%0b addr=%h exp 1/4", imem_req, imem_addr); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_async_req req=%0b addr=%h exp 0/0", imem_req, imem_addr); end
    checks++; if (instruction !== 32'h0 || pc_plus4 !== 32'h0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL rm_async_ifid got=%h/%h/%0b exp=0/0/0", instruction, pc_plus4, ifid_valid); end
    imem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_ignored valid=%0b req=%0b addr=%h exp 0/1/0", ifid_valid, imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (instruction !== 32'hA5A5_0000 || pc_plus4 !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rm_restart got=%h/%h/%0b exp=a5a50000/4/1", instruction, pc_plus4, ifid_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_branch_kill();
    test_branch_in_hold();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
